// File: rtl/bcd_7seg_scanner.sv
// Three-digit multiplexed seven-segment driver with a frame-synchronous shadow register.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module bcd_7seg_scanner #(
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter bit          COMMON_ANODE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] hundreds,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic       pending,
  output logic       frame_done
);

  localparam int unsigned PcntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PcntW-1:0] PcntMax = PcntW'(REFRESH_DIV - 1);
  localparam logic [6:0] SegOff = COMMON_ANODE ? 7'h7f : 7'h00;
  localparam logic [2:0] AnOff  = COMMON_ANODE ? 3'b111 : 3'b000;

  typedef enum logic [1:0] {SlotH, SlotT, SlotO} slot_e;

  logic [PcntW-1:0] pcnt_q, pcnt_d;
  slot_e            slot_q, slot_d;
  logic [11:0]      disp_q, disp_d;
  logic [11:0]      shadow_q, shadow_d;
  logic             pending_q, pending_d;
  logic             frame_done_q, frame_done_d;
  logic [6:0]       seg_q, seg_d;
  logic [2:0]       an_q, an_d;

  logic        tick;
  logic        boundary;
  logic [11:0] load_val;
  logic [3:0]  digit;
  logic        blank;
  logic [6:0]  seg_act;
  logic [2:0]  an_act;

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3f;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5b;
      4'd3:    s = 7'h4f;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6d;
      4'd6:    s = 7'h7d;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7f;
      4'd9:    s = 7'h6f;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  // Scan sequencing and shadow/display register handover.
  always_comb begin
    load_val     = {hundreds, tens, ones};
    tick         = (pcnt_q == PcntMax);
    boundary     = tick && (slot_q == SlotO);
    pcnt_d       = tick ? '0 : pcnt_q + PcntW'(1);
    slot_d       = slot_q;
    shadow_d     = load ? load_val : shadow_q;
    disp_d       = disp_q;
    pending_d    = pending_q;
    frame_done_d = boundary;

    if (tick) begin
      unique case (slot_q)
        SlotH:   slot_d = SlotT;
        SlotT:   slot_d = SlotO;
        default: slot_d = SlotH;
      endcase
    end

    // A load coinciding with the boundary bypasses the shadow entirely.
    if (boundary) begin
      if (load) begin
        disp_d = load_val;
      end else if (pending_q) begin
        disp_d = shadow_q;
      end
      pending_d = 1'b0;
    end else if (load) begin
      pending_d = 1'b1;
    end
  end

  // Output decode from the current slot and display register.
  always_comb begin
    digit  = disp_q[3:0];
    an_act = 3'b000;
    blank  = 1'b0;
    unique case (slot_q)
      SlotH: begin
        digit  = disp_q[11:8];
        an_act = 3'b100;
      end
      SlotT: begin
        digit  = disp_q[7:4];
        an_act = 3'b010;
      end
      SlotO: begin
        digit  = disp_q[3:0];
        an_act = 3'b001;
      end
      default: blank = 1'b1;
    endcase

`ifdef LEADING_ZERO_BLANK_EN
    if ((slot_q == SlotH) && (disp_q[11:8] == 4'd0)) blank = 1'b1;
    if ((slot_q == SlotT) && (disp_q[11:4] == 8'd0)) blank = 1'b1;
`endif

    seg_act = blank ? 7'h00 : decode(digit);
    if (blank) an_act = 3'b000;
    seg_d = COMMON_ANODE ? ~seg_act : seg_act;
    an_d  = COMMON_ANODE ? ~an_act : an_act;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q       <= '0;
      slot_q       <= SlotH;
      disp_q       <= '0;
      shadow_q     <= '0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
      seg_q        <= SegOff;
      an_q         <= AnOff;
    end else begin
      pcnt_q       <= pcnt_d;
      slot_q       <= slot_d;
      disp_q       <= disp_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign pending    = pending_q;
  assign frame_done = frame_done_q;

endmodule
